// File: rtl/i2s_capture_if.sv
// Sample-side bus of i2s_capture: held L/R pair with valid/ready handshake,
// sticky overrun with its clear, and the optional peak level.
interface i2s_capture_if;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        clr_overrun;
  logic [15:0] level;

  modport master (
    output sample_left, sample_right, sample_valid, overrun, level,
    input  sample_ready, clr_overrun
  );

  modport slave (
    input  sample_left, sample_right, sample_valid, overrun, level,
    output sample_ready, clr_overrun
  );
endinterface

// File: rtl/i2s_capture.sv
// I2S receiver: masters mclk/sck/lrck toward the codec ADC and deserializes sdout
// into 16-bit L/R pairs. Define LEVEL_METER_EN to build the peak-level meter.
module i2s_capture #(
  parameter int unsigned SYNC_STAGES  = 2,      // 2..3
  parameter logic [3:0]  SAMPLE_PHASE = 4'd11   // 8 + SYNC_STAGES .. 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  output logic           audio_mclk_o,
  output logic           audio_lrck_o,
  output logic           audio_sck_o,
  input  logic           audio_sdout_i,
  i2s_capture_if.master  smp
);

  logic [8:0]             cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [14:0]            left_sh_q, left_sh_d;
  logic [14:0]            right_sh_q, right_sh_d;
  logic [15:0]            left_word_q, left_word_d;
  logic [15:0]            left_q, left_d;
  logic [15:0]            right_q, right_d;
  logic                   first_q, first_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic        sdin, lrck, slot0, sample_hit;
  logic        left_slot, right_slot, left_done, right_done;
  logic        publish, load;
  logic [15:0] left_next, right_next;

  assign sdin       = sync_q[SYNC_STAGES-1];
  assign lrck       = cnt_q[8];
  assign slot0      = (cnt_q[7:4] == 4'd0);
  assign sample_hit = en_i && (cnt_q[3:0] == SAMPLE_PHASE);

  // One-bit I2S delay: each word's LSB lands in slot 0 of the opposite lrck half.
  assign left_slot  = sample_hit && (lrck == slot0);
  assign right_slot = sample_hit && (lrck != slot0);
  assign left_done  = left_slot && lrck;
  assign right_done = right_slot && !lrck;
  assign left_next  = {left_sh_q, sdin};
  assign right_next = {right_sh_q, sdin};

  assign publish = right_done && !first_q;
  assign load    = publish && (!valid_q || smp.sample_ready);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    left_sh_d   = left_sh_q;
    right_sh_d  = right_sh_q;
    left_word_d = left_word_q;
    left_d      = left_q;
    right_d     = right_q;
    first_d     = first_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    if (!en_i) begin
      cnt_d       = '0;
      left_sh_d   = '0;
      right_sh_d  = '0;
      left_word_d = '0;
      first_d     = 1'b1;
    end else begin
      cnt_d = cnt_q + 9'd1;
      if (left_slot)  left_sh_d   = left_next[14:0];
      if (left_done)  left_word_d = left_next;
      if (right_slot) right_sh_d  = right_next[14:0];
      // The pair completing right after enable is partial, so it is discarded.
      if (right_done) first_d = 1'b0;
    end

    if (valid_q && smp.sample_ready) valid_d = 1'b0;
    if (load) begin
      left_d  = left_word_q;
      right_d = right_next;
      valid_d = 1'b1;
    end

    if (smp.clr_overrun)   overrun_d = 1'b0;
    if (publish && !load)  overrun_d = 1'b1;
  end

  // NOTE: state is updated only here with non-blocking assignments, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sync_q      <= '0;
      left_sh_q   <= '0;
      right_sh_q  <= '0;
      left_word_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      first_q     <= 1'b1;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], audio_sdout_i};
      left_sh_q   <= left_sh_d;
      right_sh_q  <= right_sh_d;
      left_word_q <= left_word_d;
      left_q      <= left_d;
      right_q     <= right_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Clocks come straight from counter flops, so they are glitch-free and 0 when idle.
  assign audio_mclk_o     = cnt_q[1];
  assign audio_sck_o      = cnt_q[3];
  assign audio_lrck_o     = cnt_q[8];
  assign smp.sample_left  = left_q;
  assign smp.sample_right = right_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;

`ifdef LEVEL_METER_EN
  logic [15:0] level_q, level_d;

  function automatic logic [15:0] mag(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  always_comb begin
    level_d = smp.clr_overrun ? 16'h0000 : level_q;
    if (load) begin
      if (mag(left_word_q) > level_d) level_d = mag(left_word_q);
      if (mag(right_next)  > level_d) level_d = mag(right_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign smp.level = level_q;
`else
  assign smp.level = 16'h0000;
`endif

endmodule

// File: tb/tb_i2s_capture.sv
// Directed/randomized bench for i2s_capture: a behavioural I2S codec drives sdout
// from the generated clocks and records every pair it completes on the wire.
module tb_i2s_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic sdout = 1'b0;
  logic mclk, lrck, sck;

  i2s_capture_if bus();

  i2s_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .audio_mclk_o (mclk),
    .audio_lrck_o (lrck),
    .audio_sck_o  (sck),
    .audio_sdout_i(sdout),
    .smp          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int en_cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Codec model: shifts on sck falling edges, MSB one bit after each lrck change.
  typedef struct packed {logic [15:0] l; logic [15:0] r;} pair_t;
  pair_t       sent[$];
  logic [15:0] cod_l = '0, cod_r = '0, tx_l = '0, tx_r = '0;
  bit          cod_rand = 1'b1;
  bit          r_active = 1'b0;
  logic        last_lrck = 1'b0;
  int          pos = 0;

  initial forever begin
    @(negedge sck or negedge en);
    if (!en) begin
      pos = 0; last_lrck = 1'b0; r_active = 1'b0; sdout = 1'b0;
    end else begin
      if (lrck !== last_lrck) begin pos = 0; last_lrck = lrck; end
      else pos = pos + 1;
      if (pos == 1) begin
        if (!lrck) tx_l = cod_rand ? 16'($urandom) : cod_l;
        else begin tx_r = cod_rand ? 16'($urandom) : cod_r; r_active = 1'b1; end
      end
      if (pos == 0) begin
        if (lrck) sdout = tx_l[0];
        else begin
          sdout = tx_r[0];
          if (r_active) sent.push_back({tx_l, tx_r});
        end
      end else begin
        sdout = lrck ? tx_r[16-pos] : tx_l[16-pos];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return mclk;
      1:       return sck;
      default: return lrck;
    endcase
  endfunction

  task automatic period(input int which, output int p);
    int n = 0;
    p = 0;
    while (sel(which) !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    while (sel(which) !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    while (sel(which) === 1'b1 && n < 2000) begin @(negedge clk); n++; p++; end
    while (sel(which) === 1'b0 && n < 2000) begin @(negedge clk); n++; p++; end
  endtask

  task automatic wait_valid(input int limit, output int waited);
    waited = 0;
    while (bus.sample_valid !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_phase(input int p);
    while (((cyc - en_cyc) % 512) != p) @(negedge clk);
  endtask

  int    p, w;
  pair_t exp_p;
  logic [15:0] exp_level;

  initial begin
    bus.sample_ready = 1'b0;
    bus.clr_overrun  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid",   bus.sample_valid, 0);
    check("rst_left",    bus.sample_left, 0);
    check("rst_right",   bus.sample_right, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_level",   bus.level, 0);
    check("rst_clocks",  {mclk, sck, lrck}, 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_clocks", {mclk, sck, lrck}, 0);

    // Clock periods
    en = 1'b1; en_cyc = cyc; bus.sample_ready = 1'b1;
    period(0, p); check("mclk_period", p, 4);
    period(1, p); check("sck_period", p, 16);
    period(2, p); check("lrck_period", p, 512);

    rst_n = 1'b0; en = 1'b0; bus.sample_ready = 1'b0;
    #1 check("async_rst_valid", bus.sample_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed pair: first pair dropped, second appears at cnt 0x00C
    cod_rand = 1'b0; cod_l = 16'hA5C3; cod_r = 16'h1234;
    en = 1'b1; en_cyc = cyc;
    wait_valid(1200, w);
    check("first_pair_timeout", w < 1200, 1);
    check("first_pair_latency", cyc - en_cyc, 524);
    check("first_left",  bus.sample_left, 16'hA5C3);
    check("first_right", bus.sample_right, 16'h1234);
    check("first_overrun", bus.overrun, 0);

    // Overrun: hold ready low for 3 frames while the codec sends new data
    cod_rand = 1'b1;
    repeat (3 * 512) @(negedge clk);
    check("ovr_valid", bus.sample_valid, 1);
    check("ovr_left_kept",  bus.sample_left, 16'hA5C3);
    check("ovr_right_kept", bus.sample_right, 16'h1234);
    check("ovr_flag", bus.overrun, 1);
    bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
    check("ovr_cleared", bus.overrun, 0);
    wait_phase(11);
    bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
    check("ovr_set_wins", bus.overrun, 1);
    bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
    check("ovr_cleared2", bus.overrun, 0);

    // Streaming with ready held high
    bus.sample_ready = 1'b1;
    @(negedge clk);
    check("accept_drop", bus.sample_valid, 0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(600, w);
      exp_p = sent[$];
      check("stream_timeout", w < 600, 1);
      check("stream_phase", (cyc - en_cyc) % 512, 12);
      check("stream_left",  bus.sample_left, exp_p.l);
      check("stream_right", bus.sample_right, exp_p.r);
      @(negedge clk);
      check("stream_pulse_width", bus.sample_valid, 0);
    end
    bus.sample_ready = 1'b0;

    // Accept and publish in the same cycle
    wait_valid(600, w);
    exp_p = sent[$];
    check("coll_hold_timeout", w < 600, 1);
    check("coll_hold_left", bus.sample_left, exp_p.l);
    wait_phase(11);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    bus.sample_ready = 1'b0;
    exp_p = sent[$];
    check("coll_valid",   bus.sample_valid, 1);
    check("coll_left",    bus.sample_left, exp_p.l);
    check("coll_right",   bus.sample_right, exp_p.r);
    check("coll_overrun", bus.overrun, 0);

    // en dropped mid-frame: held pair survives, clocks idle
    wait_phase(9'h080);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("en_off_valid", bus.sample_valid, 1);
    check("en_off_left",  bus.sample_left, exp_p.l);
    check("en_off_right", bus.sample_right, exp_p.r);
    check("en_off_clocks", {mclk, sck, lrck}, 0);
    bus.sample_ready = 1'b1;
    @(negedge clk);
    check("en_off_consume", bus.sample_valid, 0);

    // Re-enable: first pair dropped even with ready high
    en = 1'b1; en_cyc = cyc;
    wait_valid(1200, w);
    exp_p = sent[$];
    check("reen_timeout", w < 1200, 1);
    check("reen_latency", cyc - en_cyc, 524);
    check("reen_left",  bus.sample_left, exp_p.l);
    check("reen_right", bus.sample_right, exp_p.r);

    // Peak level with a full-scale negative left sample
    bus.clr_overrun = 1'b1; @(negedge clk); bus.clr_overrun = 1'b0;
    cod_rand = 1'b0; cod_l = 16'h8000; cod_r = 16'h0123;
`ifdef LEVEL_METER_EN
    exp_level = 16'h7FFF;
`else
    exp_level = 16'h0000;
`endif
    for (int i = 0; i < 2; i++) begin
      wait_valid(600, w);
      check("lvl_timeout", w < 600, 1);
      check("lvl_left",  bus.sample_left, 16'h8000);
      check("lvl_right", bus.sample_right, 16'h0123);
      check("lvl_level", bus.level, exp_level);
      @(negedge clk);
    end

    en = 1'b0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/i2s_capture.md
Name: i2s_capture

Overview:
- Receive-side counterpart of the speaker output path. Masters the same I2S clock set (mclk/lrck/sck) toward the codec ADC (for example, the Pmod I2S2 line-in) and deserializes its sdout.
- Presents 16-bit left/right PCM pairs to game logic (clap/voice detection for the wooden-man round) through a valid/ready handshake with overrun reporting.

Parameters:
- SYNC_STAGES, 2: flops on audio_sdout before sampling; legal range 2..3.
- SAMPLE_PHASE, 4'd11: value of cnt[3:0] at which the synchronized bit is sampled. Must satisfy 8 + SYNC_STAGES <= SAMPLE_PHASE <= 15.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  capture enable; 0 holds the block idle.
- audio_mclk  out  1  master clock = clk/4.
- audio_lrck  out  1  word select = clk/512; 0 = left, 1 = right.
- audio_sck  out  1  bit clock = clk/16.
- audio_sdout  in  1  serial ADC data from the codec; asynchronous to clk.
- sample_left  out  16  signed left sample of the held pair.
- sample_right  out  16  signed right sample of the held pair.
- sample_valid  out  1  held pair is valid.
- sample_ready  in  1  consumer accepts the pair.
- overrun  out  1  sticky: a completed pair was dropped.
- clr_overrun  in  1  clears overrun (and level).
- level  out  16  peak magnitude (optional feature).

Behaviour:
- Reset (rst=0): cnt, shift registers, sync flops and all outputs are 0; the first-pair flag is set.
- Divider:
  - 9-bit cnt increments every clk while en=1. While en=0 it holds at 0 and the shift registers clear.
  - audio_mclk=cnt[1], audio_sck=cnt[3], audio_lrck=cnt[8]. All are registered, glitch-free and 0 when idle.
- Sampling:
  - audio_sdout passes through SYNC_STAGES flops.
  - One bit is sampled per sck period, at the clk where cnt[3:0]==SAMPLE_PHASE.
  - Slot k = cnt[7:4].
- I2S framing (one-bit delay):
  - lrck=0, slots 1..15 carry left bits 15..1; lrck=1, slot 0 carries left bit 0. Left word completes at cnt==9'h10B (SAMPLE_PHASE=11).
  - lrck=1, slots 1..15 carry right bits 15..1; lrck=0, slot 0 of the next frame carries right bit 0. Right word completes at cnt==9'h00B.
  - Left is latched at its completion. The pair is published when right completes.
  - Bits shift MSB-first into a 16-bit register; no sign extension or arithmetic.
- Publish (cycle after right completion):
  - If the first-pair flag is set: drop the pair, clear the flag, no valid and no overrun.
  - Else if sample_valid=0, or sample_ready=1 in the same cycle: load sample_left/right and set sample_valid.
  - Else (valid held, not ready): keep the old pair and set overrun.
- Handshake:
  - Transfer occurs on a clk edge with sample_valid && sample_ready.
  - Without a new publish that cycle, sample_valid falls the next cycle. Data stays stable while valid=1.
  - Simultaneous accept and publish: new data loads, valid stays 1, no overrun.
- overrun:
  - Stays 1 until clr_overrun=1, which clears it the next edge.
  - Overrun setting and clr in the same cycle: set wins.
- en falling mid-frame:
  - Counter and shift state clear, and the first-pair flag is set.
  - sample_valid and the held pair are kept until consumed.
- Pair rate: clk/512 (195.3 kHz at 100 MHz). Latency from the sample edge of right bit 0 to sample_valid is 1 clk.

Optional Feature:
- Macro LEVEL_METER_EN.
- Defined:
  - On every loaded pair, level <= max(level, |left|, |right|).
  - |x| of -32768 saturates to 32767.
  - clr_overrun also clears level to 0.
- Undefined: level is constant 0 and no comparator logic is built.

Test Plan:
- Reset and clock check: hold rst=0, release, en=1 -> mclk period 4 clk, sck 16 clk, lrck 512 clk, all outputs start at 0.
- Single pair: codec model drives L=16'hA5C3, R=16'h1234 every frame with standard I2S timing.
  - The first published pair is dropped.
  - The second asserts sample_valid at cnt==9'h00C with sample_left=16'hA5C3 and sample_right=16'h1234.
- Handshake: hold sample_ready=1 -> one valid pulse of 1 clk per 512 clk; sample values track the stimulus.
- Overrun: hold sample_ready=0 for 3 frames -> the first valid pair is retained and overrun=1. Pulse clr_overrun -> overrun=0.
- Accept/publish collision: assert sample_ready exactly at a publish cycle -> new pair loaded, valid stays 1, overrun stays 0.
- en toggle mid-frame (cnt=9'h080) and LEVEL_METER_EN:
  - After re-enable, the first pair is dropped and the next is correct.
  - With the macro defined and L=16'h8000, level=16'h7FFF.
